// File: rtl/uart_echo_fifo.sv
// UART echo with receive FIFO: 8x-oversampled receiver pushes good words into a circular
// buffer that a transmitter drains back out, with framing/parity/overflow pulses and TX pause.
module uart_echo_fifo #(
    parameter int unsigned DataWidth  = 8,
    parameter logic [15:0] Prescale   = 16'd1,
    parameter int unsigned FifoDepth  = 16,
    parameter int unsigned ParityMode = 0
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       rx_data_i,
    input  logic                       tx_pause_i,
    output logic                       tx_data_o,
    output logic                       frame_err_o,
    output logic                       parity_err_o,
    output logic                       overflow_o,
    output logic [$clog2(FifoDepth):0] fifo_count_o,
    output logic                       tx_busy_o
);
    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(FifoDepth);
    localparam logic [3:0] LastBit = 4'(DataWidth - 1);
    localparam logic HasParity = (ParityMode != 0);
    localparam logic OddParity = (ParityMode == 2);

    typedef enum logic [2:0] {
        RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh
    } rx_state_e;

    typedef enum logic [2:0] {
        TxIdle, TxStart, TxData, TxParity, TxStop
    } tx_state_e;

    // Synchroniser and edge history
    logic rx_meta_q, rx_meta_d;
    logic rx_sync_q, rx_sync_d;
    logic rx_prev_q, rx_prev_d;

    // Shared oversample tick
    logic [15:0] presc_q, presc_d;
    logic        tick;

    // Receiver
    rx_state_e              rx_state_q, rx_state_d;
    logic [2:0]             rx_phase_q, rx_phase_d;
    logic [3:0]             rx_bit_q, rx_bit_d;
    logic [DataWidth-1:0]   rx_shift_q, rx_shift_d;
    logic                   rx_par_q, rx_par_d;
    logic [1:0]             rx_samp_q, rx_samp_d;
    logic                   rx_bit_val;
    logic                   stop_decide;
    logic                   par_ok;
    logic                   good_word;

    // FIFO
    logic [DataWidth-1:0]   mem_q [FifoDepth];
    logic [DataWidth-1:0]   mem_d [FifoDepth];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic [DataWidth-1:0]   head_word;

    // Transmitter
    tx_state_e              tx_state_q, tx_state_d;
    logic [2:0]             tx_phase_q, tx_phase_d;
    logic [3:0]             tx_bit_q, tx_bit_d;
    logic [DataWidth-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_par_q, tx_par_d;
    logic                   tx_data_q, tx_data_d;

    always_comb begin
        rx_meta_d = rx_data_i;
        rx_sync_d = rx_meta_q;
        rx_prev_d = rx_sync_q;
        tick      = (presc_q == Prescale - 16'd1);
        presc_d   = tick ? 16'd0 : presc_q + 16'd1;
    end

    // Majority vote of phase ticks 3, 4 and the live sample at tick 5
    assign rx_bit_val = (rx_samp_q[0] & rx_samp_q[1]) | (rx_samp_q[0] & rx_sync_q) |
                        (rx_samp_q[1] & rx_sync_q);

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_phase_d  = rx_phase_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_par_d    = rx_par_q;
        rx_samp_d   = rx_samp_q;
        stop_decide = 1'b0;
        if (rx_state_q == RxIdle) begin
            if (rx_prev_q && !rx_sync_q) begin
                rx_phase_d = 3'd0;
                rx_state_d = RxStart;
            end
        end else if (rx_state_q == RxWaitHigh) begin
            if (rx_sync_q) begin
                rx_state_d = RxIdle;
            end
        end else if (tick) begin
            rx_phase_d = rx_phase_q + 3'd1;
            if (rx_phase_q == 3'd3) begin
                rx_samp_d[0] = rx_sync_q;
            end
            if (rx_phase_q == 3'd4) begin
                rx_samp_d[1] = rx_sync_q;
            end
            if (rx_phase_q == 3'd5) begin
                case (rx_state_q)
                    RxStart: begin
                        if (rx_bit_val) begin
                            rx_state_d = RxIdle;
                        end
                    end
                    RxData: begin
                        rx_shift_d = {rx_bit_val, rx_shift_q[DataWidth-1:1]};
                        rx_par_d   = rx_par_q ^ rx_bit_val;
                    end
                    RxParity: rx_par_d = rx_par_q ^ rx_bit_val;
                    RxStop: begin
                        stop_decide = 1'b1;
                        rx_state_d  = rx_bit_val ? RxIdle : RxWaitHigh;
                    end
                    default: ;
                endcase
            end
            if (rx_phase_q == 3'd7) begin
                case (rx_state_q)
                    RxStart: begin
                        rx_state_d = RxData;
                        rx_bit_d   = 4'd0;
                        rx_par_d   = 1'b0;
                    end
                    RxData: begin
                        if (rx_bit_q == LastBit) begin
                            rx_state_d = HasParity ? RxParity : RxStop;
                        end else begin
                            rx_bit_d = rx_bit_q + 4'd1;
                        end
                    end
                    RxParity: rx_state_d = RxStop;
                    default: ;
                endcase
            end
        end
    end

    assign par_ok       = !HasParity || (rx_par_q == OddParity);
    assign good_word    = stop_decide && rx_bit_val && par_ok;
    assign full         = (count_q == FullCount);
    assign head_word    = mem_q[rd_ptr_q];
    assign pop          = (tx_state_q == TxIdle) && tick && (count_q != '0) && !tx_pause_i;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign push         = good_word && (!full || pop);
    assign frame_err_o  = stop_decide && !rx_bit_val;
    assign parity_err_o = stop_decide && rx_bit_val && !par_ok;
    assign overflow_o   = good_word && full && !pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = rx_shift_q;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_phase_d = tx_phase_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        if (tx_state_q == TxIdle) begin
            if (pop) begin
                tx_state_d = TxStart;
                tx_phase_d = 3'd0;
                tx_shift_d = head_word;
                tx_par_d   = (^head_word) ^ OddParity;
            end
        end else if (tick) begin
            tx_phase_d = tx_phase_q + 3'd1;
            if (tx_phase_q == 3'd7) begin
                case (tx_state_q)
                    TxStart: begin
                        tx_state_d = TxData;
                        tx_bit_d   = 4'd0;
                    end
                    TxData: begin
                        tx_shift_d = tx_shift_q >> 1;
                        if (tx_bit_q == LastBit) begin
                            tx_state_d = HasParity ? TxParity : TxStop;
                        end else begin
                            tx_bit_d = tx_bit_q + 4'd1;
                        end
                    end
                    TxParity: tx_state_d = TxStop;
                    TxStop:   tx_state_d = TxIdle;
                    default:  ;
                endcase
            end
        end
        case (tx_state_q)
            TxStart:  tx_data_d = 1'b0;
            TxData:   tx_data_d = tx_shift_q[0];
            TxParity: tx_data_d = tx_par_q;
            default:  tx_data_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            presc_q    <= 16'd0;
            rx_state_q <= RxIdle;
            rx_phase_q <= 3'd0;
            rx_bit_q   <= 4'd0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_samp_q  <= 2'b11;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_state_q <= TxIdle;
            tx_phase_q <= 3'd0;
            tx_bit_q   <= 4'd0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_data_q  <= 1'b1;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_prev_q  <= rx_prev_d;
            presc_q    <= presc_d;
            rx_state_q <= rx_state_d;
            rx_phase_q <= rx_phase_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_samp_q  <= rx_samp_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_state_q <= tx_state_d;
            tx_phase_q <= tx_phase_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_data_o    = tx_data_q;
    assign fifo_count_o = count_q;
    assign tx_busy_o    = (tx_state_q != TxIdle);

endmodule
